// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the fetch-stage program-counter unit.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    BRANCH = 3'd1,
    JAL    = 3'd2,
    JALR   = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5
  } pc_mode_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/pc_unit_ras.sv
// Return-address stack: circular buffer with a top pointer and an occupancy count.
module pc_unit_ras #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(RAS_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    count;
  logic [AW-1:0]    inc_idx;
  logic [PW-1:0]    dec_ptr;

  // ptr addresses the top entry; a push writes the slot after it, so a
  // full stack silently overwrites its oldest entry.
  assign inc_idx = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr[AW-1:0] + AW'(1);
  assign dec_ptr = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - PW'(1);

  assign rdata = mem[ptr[AW-1:0]];
  assign empty = (count == '0);
  assign full  = (count == PW'(RAS_DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= {1'b0, inc_idx};
      if (!full) begin
        count <= count + PW'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= dec_ptr;
      count <= count - PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[inc_idx] <= wdata;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with mode-selected next-PC, misalignment trap
// and a return-address stack for call/return prediction.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       mode,
  input  logic             flag,
  input  logic [WIDTH-1:0] pcoffset,
  input  logic [WIDTH-1:0] rs1,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcnext,
  output logic [WIDTH-1:0] linkaddr,
  output logic             taken,
  output logic             misaligned,
  output logic             ras_empty,
  output logic             ras_full
);

  logic [WIDTH-1:0] rel_target;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] jalr_target;
  logic [WIDTH-1:0] ras_top;
  logic             push_req;
  logic             pop_req;
  logic             mis_now;
  logic             advance;

  assign linkaddr    = pc + WIDTH'(INST_BYTES);
  assign rel_target  = pc + pcoffset;
  assign jalr_sum    = rs1 + pcoffset;
  assign jalr_target = jalr_sum & ~WIDTH'(1);

  always_comb begin
    pcnext   = linkaddr;
    taken    = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    case (pc_mode_t'(mode))
      BRANCH: begin
        taken = flag;
        if (flag) pcnext = rel_target;
      end
      JAL: begin
        taken  = 1'b1;
        pcnext = rel_target;
      end
      JALR: begin
        taken  = 1'b1;
        pcnext = jalr_target;
      end
      CALL: begin
        taken    = 1'b1;
        pcnext   = rel_target;
        push_req = 1'b1;
      end
      RET: begin
        taken   = 1'b1;
        pcnext  = ras_empty ? jalr_target : ras_top;
        pop_req = !ras_empty;
      end
      default: ;
    endcase
  end

  assign mis_now = taken && (pcnext[1:0] != 2'b00);
  assign advance = !stall && !mis_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= RESET_PC;
      misaligned <= 1'b0;
    end else if (stall) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= mis_now;
      if (!mis_now) begin
        pc <= pcnext;
      end
    end
  end

  pc_unit_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock (clock),
    .reset (reset),
    .push  (push_req && advance),
    .pop   (pop_req && advance),
    .wdata (linkaddr),
    .rdata (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_pc_unit;

  localparam int unsigned    W     = 32;
  localparam logic [W-1:0]   RPC   = 32'h100;
  localparam int unsigned    DEPTH = 4;

  localparam logic [2:0] M_SEQ = 3'd0, M_BR = 3'd1, M_JAL = 3'd2, M_JALR = 3'd3,
                         M_CALL = 3'd4, M_RET = 3'd5;

  logic         clock = 1'b0;
  logic         reset;
  logic         stall;
  logic [2:0]   mode;
  logic         flag;
  logic [W-1:0] pcoffset;
  logic [W-1:0] rs1;
  logic [W-1:0] pc, pcnext, linkaddr;
  logic         taken, misaligned, ras_empty, ras_full;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [W-1:0] mpc;
  logic         mmis;
  logic [W-1:0] mras[$];

  always #5 clock = ~clock;

  pc_unit #(
    .WIDTH     (W),
    .RESET_PC  (RPC),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .mode       (mode),
    .flag       (flag),
    .pcoffset   (pcoffset),
    .rs1        (rs1),
    .pc         (pc),
    .pcnext     (pcnext),
    .linkaddr   (linkaddr),
    .taken      (taken),
    .misaligned (misaligned),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full)
  );

  function automatic logic [W-1:0] m_target();
    logic [W-1:0] j;
    j = (rs1 + pcoffset) & ~32'd1;
    case (mode)
      M_BR:           return flag ? mpc + pcoffset : mpc + 4;
      M_JAL, M_CALL:  return mpc + pcoffset;
      M_JALR:         return j;
      M_RET:          return (mras.size() > 0) ? mras[$] : j;
      default:        return mpc + 4;
    endcase
  endfunction

  function automatic logic m_taken();
    return (mode inside {M_JAL, M_JALR, M_CALL, M_RET}) || (mode == M_BR && flag);
  endfunction

  task automatic drive(input logic [2:0] m, input logic f, input logic [W-1:0] off,
                       input logic [W-1:0] r, input logic st);
    mode = m; flag = f; pcoffset = off; rs1 = r; stall = st;
    #1;
  endtask

  // One clock edge: advance the model with the inputs currently applied.
  task automatic step();
    logic [W-1:0] tgt;
    logic         bad;
    tgt = m_target();
    bad = m_taken() && (tgt[1:0] != 2'b00);
    @(posedge clock);
    if (reset) begin
      mpc = RPC; mmis = 1'b0; mras.delete();
    end else if (stall) begin
      mmis = 1'b0;
    end else begin
      mmis = bad;
      if (!bad) begin
        if (mode == M_CALL) begin
          mras.push_back(mpc + 4);
          if (mras.size() > DEPTH) void'(mras.pop_front());
        end else if (mode == M_RET && mras.size() > 0) begin
          void'(mras.pop_back());
        end
        mpc = tgt;
      end
    end
    #1;
  endtask

  task automatic goto_pc(input logic [W-1:0] a);
    drive(M_JAL, 1'b0, a - mpc, '0, 1'b0);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(M_SEQ, 1'b0, '0, '0, 1'b1);
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    vectors++;
    if (pc !== 32'h100) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc, 32'h100); end
    vectors++;
    if (ras_empty !== 1'b1 || ras_full !== 1'b0 || misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got e=%b f=%b m=%b want e=1 f=0 m=0", ras_empty, ras_full, misaligned);
    end
    vectors++;
    if (linkaddr !== 32'h104) begin miscompares++; $display("FAIL reset_link got %h want %h", linkaddr, 32'h104); end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(M_SEQ, 1'b0, '0, '0, 1'b0);
      step();
      vectors++;
      if (pc !== 32'h100 + 32'(4 * i)) begin
        miscompares++; $display("FAIL seq_%0d got %h want %h", i, pc, 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h200);
    drive(M_BR, 1'b0, 32'hFFFF_FFF8, '0, 1'b0);
    vectors++;
    if (taken !== 1'b0 || pcnext !== 32'h204) begin
      miscompares++; $display("FAIL br_nt got t=%b n=%h want t=0 n=204", taken, pcnext);
    end
    step();
    vectors++;
    if (pc !== 32'h204) begin miscompares++; $display("FAIL br_nt_pc got %h want 204", pc); end
    goto_pc(32'h200);
    drive(M_BR, 1'b1, 32'hFFFF_FFF8, '0, 1'b0);
    vectors++;
    if (taken !== 1'b1 || pcnext !== 32'h1F8) begin
      miscompares++; $display("FAIL br_t got t=%b n=%h want t=1 n=1f8", taken, pcnext);
    end
    step();
    vectors++;
    if (pc !== 32'h1F8) begin miscompares++; $display("FAIL br_t_pc got %h want 1f8", pc); end
  endtask

  task automatic test_jalr_misalign();
    drive(M_JALR, 1'b0, 32'h10, 32'h1001, 1'b0);
    step();
    vectors++;
    if (pc !== 32'h1010) begin miscompares++; $display("FAIL jalr got %h want 1010", pc); end
    drive(M_JALR, 1'b0, 32'h0, 32'h1002, 1'b0);
    step();
    vectors++;
    if (pc !== 32'h1010 || misaligned !== 1'b1) begin
      miscompares++; $display("FAIL misalign got pc=%h m=%b want pc=1010 m=1", pc, misaligned);
    end
    drive(M_SEQ, 1'b0, '0, '0, 1'b0);
    step();
    vectors++;
    if (pc !== 32'h1014 || misaligned !== 1'b0) begin
      miscompares++; $display("FAIL misalign_clr got pc=%h m=%b want pc=1014 m=0", pc, misaligned);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    goto_pc(32'h40);
    drive(M_CALL, 1'b0, 32'h100, '0, 1'b0);
    vectors++;
    if (linkaddr !== 32'h44) begin miscompares++; $display("FAIL call_link got %h want 44", linkaddr); end
    step();
    vectors++;
    if (pc !== 32'h140 || ras_empty !== 1'b0) begin
      miscompares++; $display("FAIL call got pc=%h e=%b want pc=140 e=0", pc, ras_empty);
    end
    drive(M_RET, 1'b0, '0, 32'h999, 1'b0);
    step();
    vectors++;
    if (pc !== 32'h44 || ras_empty !== 1'b1) begin
      miscompares++; $display("FAIL ret got pc=%h e=%b want pc=44 e=1", pc, ras_empty);
    end
  endtask

  task automatic test_back_to_back_overflow();
    logic [W-1:0] exp;
    do_reset();
    goto_pc(32'h0C);
    for (int i = 0; i < 5; i++) begin
      drive(M_CALL, 1'b0, 32'h10, '0, 1'b0);
      step();
    end
    vectors++;
    if (ras_full !== 1'b1) begin miscompares++; $display("FAIL ras_full got %b want 1", ras_full); end
    for (int i = 0; i < 4; i++) begin
      drive(M_RET, 1'b0, '0, 32'h500, 1'b0);
      step();
      exp = 32'h50 - 32'(16 * i);
      vectors++;
      if (pc !== exp) begin miscompares++; $display("FAIL ret_%0d got %h want %h", i, pc, exp); end
    end
    vectors++;
    if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL ras_drain got e=%b want 1", ras_empty); end
    drive(M_RET, 1'b0, '0, 32'h300, 1'b0);
    step();
    vectors++;
    if (pc !== 32'h300) begin miscompares++; $display("FAIL ret_underflow got %h want 300", pc); end
  endtask

  task automatic test_stall();
    do_reset();
    goto_pc(32'h80);
    drive(M_CALL, 1'b0, 32'h40, '0, 1'b1);
    step();
    step();
    vectors++;
    if (pc !== 32'h80 || ras_empty !== 1'b1) begin
      miscompares++; $display("FAIL stall_hold got pc=%h e=%b want pc=80 e=1", pc, ras_empty);
    end
    drive(M_CALL, 1'b0, 32'h40, '0, 1'b0);
    step();
    vectors++;
    if (pc !== 32'hC0 || ras_empty !== 1'b0) begin
      miscompares++; $display("FAIL stall_release got pc=%h e=%b want pc=c0 e=0", pc, ras_empty);
    end
    drive(M_RET, 1'b0, '0, 32'h700, 1'b0);
    step();
    vectors++;
    if (pc !== 32'h84 || ras_empty !== 1'b1) begin
      miscompares++; $display("FAIL stall_push_once got pc=%h e=%b want pc=84 e=1", pc, ras_empty);
    end
    // reset during a stalled RET discards the pop
    drive(M_CALL, 1'b0, 32'h40, '0, 1'b0);
    step();
    reset = 1'b1;
    drive(M_RET, 1'b0, '0, '0, 1'b1);
    step();
    reset = 1'b0;
    vectors++;
    if (pc !== RPC || ras_empty !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid got pc=%h e=%b want pc=%h e=1", pc, ras_empty, RPC);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] off;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      off = $urandom();
      if ($urandom_range(0, 7) != 0) off[1:0] = 2'b00;
      drive(3'($urandom_range(0, 7)), 1'($urandom), off, $urandom(),
            ($urandom_range(0, 7) == 0));
      vectors++;
      if (pcnext !== m_target() || taken !== m_taken() || linkaddr !== mpc + 4) begin
        miscompares++;
        $display("FAIL rnd_comb[%0d] got n=%h t=%b l=%h want n=%h t=%b l=%h",
                 i, pcnext, taken, linkaddr, m_target(), m_taken(), mpc + 4);
      end
      step();
      vectors++;
      if (pc !== mpc || misaligned !== mmis || ras_empty !== (mras.size() == 0)
          || ras_full !== (mras.size() == DEPTH)) begin
        miscompares++;
        $display("FAIL rnd_state[%0d] got pc=%h m=%b e=%b f=%b want pc=%h m=%b e=%b f=%b",
                 i, pc, misaligned, ras_empty, ras_full, mpc, mmis,
                 (mras.size() == 0), (mras.size() == DEPTH));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; mode = M_SEQ; flag = 1'b0; pcoffset = '0; rs1 = '0;
    mpc = RPC; mmis = 1'b0;
    @(negedge clock);
    test_reset();
    test_branch();
    test_jalr_misalign();
    test_call_ret();
    test_back_to_back_overflow();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
